// File: rtl/elevator_call_panel.sv
// Call-button front end: debounce, latch, arrival detect, door dwell.
// Define CALL_PANEL_DEBOUNCE_EN to include the per-button debounce counters.
module elevator_call_panel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ARRIVE_CYCLES   = 2,
   parameter int DWELL_CYCLES    = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] btn,
   input  logic [2:0] floor_number,
   input  logic       move,
   output logic       f1,
   output logic       f2,
   output logic       f3,
   output logic       f4,
   output logic       f5,
   output logic [4:0] pending,
   output logic       door_open,
   output logic       arrived,
   output logic       door_fault
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
       ARRIVE_CYCLES < 1 || ARRIVE_CYCLES > 15 ||
       DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_param
      $error("elevator_call_panel: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   localparam logic [3:0] ARR   = 4'(ARRIVE_CYCLES);
   localparam logic [7:0] DWELL = 8'(DWELL_CYCLES);

   state_t     state;
   state_t     state_nx;
   logic [4:0] btn_s;
   logic [4:0] press;
   logic [4:0] fl_hot;
   logic [4:0] pend_nx;
   logic [4:0] f_q;
   logic [3:0] arr_cnt;
   logic [3:0] arr_cnt_nx;
   logic [7:0] dwell;
   logic [7:0] dwell_nx;

   always_ff @(posedge clock) begin
      if (reset) btn_s <= '0;
      else       btn_s <= btn;
   end

`ifdef CALL_PANEL_DEBOUNCE_EN
   localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

   logic [3:0] deb_cnt [5];
   logic [4:0] press_q;

   // press_q pulses on the edge the count saturates, once per hold
   always_ff @(posedge clock) begin
      if (reset) begin
         press_q <= '0;
         for (int k = 0; k < 5; k++) deb_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            press_q[k] <= btn_s[k] && (deb_cnt[k] == DEB - 4'd1);
            if (!btn_s[k])
               deb_cnt[k] <= '0;
            else if (deb_cnt[k] != DEB)
               deb_cnt[k] <= deb_cnt[k] + 4'd1;
         end
      end
   end

   assign press = press_q;
`else
   logic [4:0] btn_d;

   always_ff @(posedge clock) begin
      if (reset) btn_d <= '0;
      else       btn_d <= btn_s;
   end

   assign press = btn_s & ~btn_d;
`endif

   always_comb begin
      fl_hot = '0;
      if (floor_number >= 3'd1 && floor_number <= 3'd5)
         fl_hot[floor_number - 3'd1] = 1'b1;
   end

   always_comb begin
      state_nx   = state;
      arr_cnt_nx = arr_cnt;
      dwell_nx   = dwell;
      pend_nx    = pending | press;
      unique case (state)
         IDLE: begin
            if (!move && ((pending & fl_hot) != '0)) begin
               if (arr_cnt == ARR - 4'd1) begin
                  state_nx   = OPEN;
                  arr_cnt_nx = '0;
                  dwell_nx   = DWELL;
                  pend_nx    = pend_nx & ~fl_hot;
               end else begin
                  arr_cnt_nx = arr_cnt + 4'd1;
               end
            end else begin
               arr_cnt_nx = '0;
            end
         end
         OPEN: begin
            // a call for the floor we are at holds the doors instead
            pend_nx = pending | (press & ~fl_hot);
            if ((press & fl_hot) != '0) begin
               dwell_nx = DWELL;
            end else if (dwell == 8'd1) begin
               dwell_nx = '0;
               state_nx = CLOSE;
            end else begin
               dwell_nx = dwell - 8'd1;
            end
         end
         CLOSE: begin
            state_nx   = IDLE;
            arr_cnt_nx = '0;
         end
         default: begin
            state_nx   = IDLE;
            arr_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         arr_cnt    <= '0;
         dwell      <= '0;
         pending    <= '0;
         f_q        <= '0;
         door_open  <= 1'b0;
         arrived    <= 1'b0;
         door_fault <= 1'b0;
      end else begin
         state      <= state_nx;
         arr_cnt    <= arr_cnt_nx;
         dwell      <= dwell_nx;
         pending    <= pend_nx;
         f_q        <= (state_nx == IDLE) ? pend_nx : 5'b0;
         door_open  <= (state_nx == OPEN);
         arrived    <= (state == IDLE) && (state_nx == OPEN);
         door_fault <= door_fault | ((state == OPEN) && move);
      end
   end

   assign f1 = f_q[0];
   assign f2 = f_q[1];
   assign f3 = f_q[2];
   assign f4 = f_q[3];
   assign f5 = f_q[4];

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel at default parameters.
// Expected latencies follow the CALL_PANEL_DEBOUNCE_EN setting.
module tb_elevator_call_panel;

`ifdef CALL_PANEL_DEBOUNCE_EN
   localparam int LAT  = 6;
   localparam int HOLD = 5;
`else
   localparam int LAT  = 2;
   localparam int HOLD = 1;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] btn;
   logic [2:0] floor_number;
   logic       move;
   logic       f1, f2, f3, f4, f5;
   logic [4:0] pending;
   logic       door_open;
   logic       arrived;
   logic       door_fault;
   logic [4:0] f;

   int checks = 0;
   int errors = 0;

   assign f = {f5, f4, f3, f2, f1};

   elevator_call_panel dut (
      .clock        (clock),
      .reset        (reset),
      .btn          (btn),
      .floor_number (floor_number),
      .move         (move),
      .f1           (f1),
      .f2           (f2),
      .f3           (f3),
      .f4           (f4),
      .f5           (f5),
      .pending      (pending),
      .door_open    (door_open),
      .arrived      (arrived),
      .door_fault   (door_fault)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn = '0;
      move = 1'b0;
      floor_number = 3'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // latch calls while parked at an invalid floor
   task automatic latch(input logic [4:0] b);
      btn = b;
      repeat (HOLD) tick();
      btn = '0;
      repeat (LAT - HOLD) tick();
   endtask

   task automatic test_reset();
      logic [12:0] o;
      reset = 1'b1;
      btn = 5'b11111;
      move = 1'b0;
      floor_number = 3'd1;
      for (int i = 0; i < 8; i++) begin
         tick();
         o = {f, pending, door_open, arrived, door_fault};
         checks++;
         if (o !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %b want 0", i, o);
         end
      end
      reset = 1'b0;
      btn = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         o = {f, pending, door_open, arrived, door_fault};
         checks++;
         if (o !== 13'd0) begin
            errors++;
            $display("FAIL reset_release cyc %0d got %b want 0", i, o);
         end
      end
   endtask

   task automatic test_debounce();
      do_reset();
`ifdef CALL_PANEL_DEBOUNCE_EN
      btn = 5'b00001;
      repeat (3) tick();
      btn = '0;
      repeat (8) tick();
      checks++;
      if (f1 !== 1'b0 || pending !== 5'b0) begin
         errors++;
         $display("FAIL glitch f1 %b pend %b want 0", f1, pending);
      end
`endif
      btn = 5'b00001;
      for (int i = 1; i <= LAT; i++) begin
         tick();
         checks++;
         if (f1 !== (i == LAT)) begin
            errors++;
            $display("FAIL press_lat edge %0d got %b want %b",
                     i, f1, i == LAT);
         end
      end
      checks++;
      if (pending !== 5'b00001) begin
         errors++;
         $display("FAIL press_pend got %b want 00001", pending);
      end
      btn = '0;
      repeat (3) tick();
      checks++;
      if (f1 !== 1'b1) begin
         errors++;
         $display("FAIL press_keep got %b want 1", f1);
      end
   endtask

   task automatic test_arrival();
      do_reset();
      latch(5'b00001);
      floor_number = 3'd1;
      tick();
      checks++;
      if ({f1, door_open, arrived} !== 3'b100) begin
         errors++;
         $display("FAIL arr_wait got %b want 100",
                  {f1, door_open, arrived});
      end
      tick();
      checks++;
      if ({f1, door_open, arrived, pending} !== 8'b0110_0000) begin
         errors++;
         $display("FAIL arr_open got %b want 01100000",
                  {f1, door_open, arrived, pending});
      end
      for (int i = 2; i <= 8; i++) begin
         tick();
         checks++;
         if ({door_open, arrived, f1} !== 3'b100) begin
            errors++;
            $display("FAIL arr_dwell cyc %0d got %b want 100",
                     i, {door_open, arrived, f1});
         end
      end
      tick();
      checks++;
      if ({door_open, arrived} !== 2'b00) begin
         errors++;
         $display("FAIL arr_close got %b want 00",
                  {door_open, arrived});
      end
      tick();
      checks++;
      if ({door_open, arrived, pending, f} !== 12'd0) begin
         errors++;
         $display("FAIL arr_idle got %b want 0",
                  {door_open, arrived, pending, f});
      end
   endtask

   task automatic test_open_call();
      do_reset();
      latch(5'b00001);
      floor_number = 3'd1;
      tick();
      tick();
      latch(5'b00100);
      checks++;
      if ({pending[2], f3, door_open} !== 3'b101) begin
         errors++;
         $display("FAIL open_call_latch got %b want 101",
                  {pending[2], f3, door_open});
      end
      repeat (7 - LAT) tick();
      checks++;
      if ({f3, door_open} !== 2'b01) begin
         errors++;
         $display("FAIL open_call_last got %b want 01",
                  {f3, door_open});
      end
      tick();
      checks++;
      if ({f3, door_open} !== 2'b00) begin
         errors++;
         $display("FAIL open_call_close got %b want 00",
                  {f3, door_open});
      end
      tick();
      checks++;
      if ({f3, door_open, pending} !== 7'b1000100) begin
         errors++;
         $display("FAIL open_call_idle got %b want 1000100",
                  {f3, door_open, pending});
      end
   endtask

   task automatic test_dwell_extend();
      int e1;
      int opens;
      logic want;
      do_reset();
      latch(5'b00010);
      tick();
      floor_number = 3'd2;
      e1 = 8 - LAT;
      opens = 0;
      for (int n = 1; n <= 16; n++) begin
         btn[1] = (n >= e1) && (n < e1 + HOLD);
         tick();
         want = (n >= 2) && (n <= 14);
         if (door_open) opens++;
         checks++;
         if (door_open !== want || pending[1] !== (n < 2)) begin
            errors++;
            $display("FAIL dwell_ext edge %0d door %b pend %b want %b %b",
                     n, door_open, pending[1], want, n < 2);
         end
      end
      btn = '0;
      checks++;
      if (opens != 13) begin
         errors++;
         $display("FAIL dwell_total got %0d want 13", opens);
      end
   endtask

   task automatic test_multi_invalid();
      do_reset();
      latch(5'b10101);
      checks++;
      if ({f, pending} !== 10'b10101_10101) begin
         errors++;
         $display("FAIL multi_latch got %b want 1010110101",
                  {f, pending});
      end
      floor_number = 3'd7;
      repeat (4) tick();
      floor_number = 3'd6;
      repeat (4) tick();
      checks++;
      if ({door_open, pending} !== 6'b0_10101) begin
         errors++;
         $display("FAIL invalid_floor got %b want 010101",
                  {door_open, pending});
      end
      floor_number = 3'd3;
      move = 1'b1;
      repeat (4) tick();
      checks++;
      if ({door_open, arrived, pending} !== 7'b00_10101) begin
         errors++;
         $display("FAIL moving_pass got %b want 0010101",
                  {door_open, arrived, pending});
      end
      move = 1'b0;
      tick();
      tick();
      checks++;
      if ({door_open, arrived, f} !== 7'b11_00000) begin
         errors++;
         $display("FAIL floor3_open got %b want 1100000",
                  {door_open, arrived, f});
      end
   endtask

   task automatic test_fault();
      do_reset();
      latch(5'b00001);
      floor_number = 3'd1;
      tick();
      tick();
      move = 1'b1;
      tick();
      move = 1'b0;
      checks++;
      if (door_fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_set got %b want 1", door_fault);
      end
      tick();
      tick();
      checks++;
      if ({door_fault, door_open} !== 2'b11) begin
         errors++;
         $display("FAIL fault_sticky got %b want 11",
                  {door_fault, door_open});
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({door_open, door_fault, arrived, pending, f} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset got %b want 0",
                  {door_open, door_fault, arrived, pending, f});
      end
      reset = 1'b0;
      floor_number = 3'd0;
      latch(5'b01000);
      checks++;
      if ({f, door_open, door_fault} !== 7'b01000_00) begin
         errors++;
         $display("FAIL post_reset_idle got %b want 0100000",
                  {f, door_open, door_fault});
      end
   endtask

   initial begin
      reset = 1'b1;
      btn = '0;
      floor_number = 3'd0;
      move = 1'b0;
      test_reset();
      test_debounce();
      test_arrival();
      test_open_call();
      test_dwell_extend();
      test_multi_invalid();
      test_fault();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
